// File: rtl/output_queue_demux_pkg.sv
// Shared constants for the output-queue demux: IOQ header field positions,
// the header ctrl marker and the demux state encodings.
package output_queue_demux_pkg;

    // Bit offsets of fields inside the IOQ module header word.
    localparam int IOQ_DST_PORT_POS = 48;
    localparam int IOQ_SRC_PORT_POS = 16;

    localparam logic [7:0] IO_QUEUE_STAGE_NUM = 8'hFF;

    localparam logic [1:0] WAIT_HDR = 2'd0;
    localparam logic [1:0] FWD_HDR  = 2'd1;
    localparam logic [1:0] FWD_DATA = 2'd2;
    localparam logic [1:0] DROP     = 2'd3;

endpackage

// File: rtl/output_queue_demux_fallthrough_small_fifo.sv
// Small first-word-fall-through FIFO: the head entry is visible on o_dout
// whenever o_empty is low. Writes while full are discarded.
module fallthrough_small_fifo #(
    parameter int WIDTH          = 72,
    parameter int MAX_DEPTH_BITS = 2
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic [WIDTH-1:0] i_din,
    input  logic             i_wr_en,
    input  logic             i_rd_en,
    output logic [WIDTH-1:0] o_dout,
    output logic             o_full,
    output logic             o_nearly_full,
    output logic             o_empty
);
    localparam int DEPTH = 1 << MAX_DEPTH_BITS;

    logic [WIDTH-1:0]          r_mem [DEPTH];
    logic [MAX_DEPTH_BITS-1:0] r_wr_ptr;
    logic [MAX_DEPTH_BITS-1:0] r_rd_ptr;
    logic [MAX_DEPTH_BITS:0]   r_count;
    logic                      w_wr;
    logic                      w_rd;

    assign o_full        = (r_count == (MAX_DEPTH_BITS+1)'(DEPTH));
    assign o_nearly_full = (r_count >= (MAX_DEPTH_BITS+1)'(DEPTH - 1));
    assign o_empty       = (r_count == '0);
    assign o_dout        = r_mem[r_rd_ptr];
    assign w_wr          = i_wr_en && !o_full;
    assign w_rd          = i_rd_en && !o_empty;

    always_ff @(posedge i_clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= i_din;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr) r_wr_ptr <= r_wr_ptr + MAX_DEPTH_BITS'(1);
            if (w_rd) r_rd_ptr <= r_rd_ptr + MAX_DEPTH_BITS'(1);
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + (MAX_DEPTH_BITS+1)'(1);
                2'b01:   r_count <= r_count - (MAX_DEPTH_BITS+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/output_queue_demux.sv
// Decodes the IOQ header destination bitmap and strobes each packet word into
// every selected output queue. Build with OQ_DEMUX_MIRROR_EN to mirror all
// forwarded packets (and zero-mask packets) to queue MIRROR_QUEUE.
module output_queue_demux
    import output_queue_demux_pkg::*;
#(
    parameter int         DATA_WIDTH         = 64,
    parameter int         CTRL_WIDTH         = DATA_WIDTH / 8,
    parameter int         NUM_OUTPUT_QUEUES  = 8,
    parameter logic [7:0] IO_QUEUE_STAGE_NUM = output_queue_demux_pkg::IO_QUEUE_STAGE_NUM,
    parameter int         CNT_WIDTH          = 16,
    parameter int         MIRROR_QUEUE       = 1
) (
    input  logic                         i_clk,
    input  logic                         i_reset,      // active-low, asynchronous
    input  logic [DATA_WIDTH-1:0]        i_in_data,
    input  logic [CTRL_WIDTH-1:0]        i_in_ctrl,
    input  logic                         i_in_wr,
    output logic                         o_in_rdy,
    output logic [DATA_WIDTH-1:0]        o_out_data,
    output logic [CTRL_WIDTH-1:0]        o_out_ctrl,
    output logic [NUM_OUTPUT_QUEUES-1:0] o_out_wr,
    input  logic [NUM_OUTPUT_QUEUES-1:0] i_out_rdy,
    output logic [CNT_WIDTH-1:0]         o_pkt_fwd_cnt,
    output logic [CNT_WIDTH-1:0]         o_pkt_drop_cnt,
    output logic [1:0]                   o_state
);
    if (MIRROR_QUEUE < 0 || MIRROR_QUEUE >= NUM_OUTPUT_QUEUES) begin : g_bad_mirror
        $error("MIRROR_QUEUE out of range");
    end

    logic [1:0]                   r_state;
    logic [NUM_OUTPUT_QUEUES-1:0] r_dst_mask;
    logic [NUM_OUTPUT_QUEUES-1:0] r_out_wr;
    logic [DATA_WIDTH-1:0]        r_out_data;
    logic [CTRL_WIDTH-1:0]        r_out_ctrl;
    logic [CNT_WIDTH-1:0]         r_fwd_cnt;
    logic [CNT_WIDTH-1:0]         r_drop_cnt;
    logic                         r_drop_data;

    logic [DATA_WIDTH-1:0]        w_head_data;
    logic [CTRL_WIDTH-1:0]        w_head_ctrl;
    logic                         w_empty;
    logic                         w_full;
    logic                         w_nearly_full;
    logic [NUM_OUTPUT_QUEUES-1:0] w_new_mask;
    logic                         w_is_hdr;
    logic                         w_ctrl_zero;
    logic                         w_fwd_go;
    logic                         w_fwd_pop;
    logic                         w_drop_pop;

    fallthrough_small_fifo #(
        .WIDTH          (CTRL_WIDTH + DATA_WIDTH),
        .MAX_DEPTH_BITS (2)
    ) u_in_fifo (
        .i_clk         (i_clk),
        .i_reset       (i_reset),
        .i_din         ({i_in_ctrl, i_in_data}),
        .i_wr_en       (i_in_wr),
        .i_rd_en       (w_fwd_pop || w_drop_pop),
        .o_dout        ({w_head_ctrl, w_head_data}),
        .o_full        (w_full),
        .o_nearly_full (w_nearly_full),
        .o_empty       (w_empty)
    );

`ifdef OQ_DEMUX_MIRROR_EN
    assign w_new_mask = w_head_data[IOQ_DST_PORT_POS +: NUM_OUTPUT_QUEUES]
                      | (NUM_OUTPUT_QUEUES'(1) << MIRROR_QUEUE);
`else
    assign w_new_mask = w_head_data[IOQ_DST_PORT_POS +: NUM_OUTPUT_QUEUES];
`endif

    assign w_is_hdr    = (w_head_ctrl == CTRL_WIDTH'(IO_QUEUE_STAGE_NUM));
    assign w_ctrl_zero = (w_head_ctrl == '0);
    // Unselected queues are masked out so they can never stall the packet.
    assign w_fwd_go    = !w_empty && (&(i_out_rdy | ~r_dst_mask));
    assign w_fwd_pop   = ((r_state == FWD_HDR) || (r_state == FWD_DATA)) && w_fwd_go;
    assign w_drop_pop  = (r_state == DROP) && !w_empty;

    assign o_in_rdy       = !w_nearly_full;
    assign o_out_data     = r_out_data;
    assign o_out_ctrl     = r_out_ctrl;
    assign o_out_wr       = r_out_wr;
    assign o_pkt_fwd_cnt  = r_fwd_cnt;
    assign o_pkt_drop_cnt = r_drop_cnt;
    assign o_state        = r_state;

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state     <= WAIT_HDR;
            r_dst_mask  <= '0;
            r_out_wr    <= '0;
            r_out_data  <= '0;
            r_out_ctrl  <= '0;
            r_fwd_cnt   <= '0;
            r_drop_cnt  <= '0;
            r_drop_data <= 1'b0;
        end else begin
            r_out_wr <= w_fwd_pop ? r_dst_mask : '0;
            if (w_fwd_pop) begin
                r_out_data <= w_head_data;
                r_out_ctrl <= w_head_ctrl;
            end
            case (r_state)
                WAIT_HDR: begin
                    // Decode only; the header word stays in the FIFO so it is forwarded too.
                    if (!w_empty) begin
                        r_drop_data <= 1'b0;
                        r_dst_mask  <= w_is_hdr ? w_new_mask : '0;
                        if (w_is_hdr && (|w_new_mask)) begin
                            r_state <= FWD_HDR;
                        end else begin
                            r_state <= DROP;
                            if (r_drop_cnt != '1) r_drop_cnt <= r_drop_cnt + CNT_WIDTH'(1);
                        end
                    end
                end
                FWD_HDR: begin
                    if (w_fwd_pop && w_ctrl_zero) r_state <= FWD_DATA;
                end
                FWD_DATA: begin
                    if (w_fwd_pop && !w_ctrl_zero) begin
                        r_state <= WAIT_HDR;
                        if (r_fwd_cnt != '1) r_fwd_cnt <= r_fwd_cnt + CNT_WIDTH'(1);
                    end
                end
                default: begin
                    // DROP: same header/data/EOP tracking as forwarding, without strobes.
                    if (w_drop_pop) begin
                        if (!r_drop_data) begin
                            if (w_ctrl_zero) r_drop_data <= 1'b1;
                        end else if (!w_ctrl_zero) begin
                            r_drop_data <= 1'b0;
                            r_state     <= WAIT_HDR;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_output_queue_demux.sv
// Directed bench for output_queue_demux: unicast, flood with stall, empty
// mask, bad header, back-to-back packets and mid-packet reset.
module tb_output_queue_demux;
  localparam int W = 80;

  logic        clk = 1'b0;
  logic        i_reset;
  logic [63:0] i_in_data;
  logic [7:0]  i_in_ctrl;
  logic        i_in_wr;
  logic        o_in_rdy;
  logic [63:0] o_out_data;
  logic [7:0]  o_out_ctrl;
  logic [7:0]  o_out_wr;
  logic [7:0]  i_out_rdy;
  logic [15:0] o_pkt_fwd_cnt;
  logic [15:0] o_pkt_drop_cnt;
  logic [1:0]  o_state;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] obs_q[$];
  int           obs_t[$];
  int           cyc = 0;
  int           n_tests = 0;
  int           n_fail = 0;
  int           exp_fwd = 0;
  int           exp_drop = 0;

  output_queue_demux dut (
    .i_clk          (clk),
    .i_reset        (i_reset),
    .i_in_data      (i_in_data),
    .i_in_ctrl      (i_in_ctrl),
    .i_in_wr        (i_in_wr),
    .o_in_rdy       (o_in_rdy),
    .o_out_data     (o_out_data),
    .o_out_ctrl     (o_out_ctrl),
    .o_out_wr       (o_out_wr),
    .i_out_rdy      (i_out_rdy),
    .o_pkt_fwd_cnt  (o_pkt_fwd_cnt),
    .o_pkt_drop_cnt (o_pkt_drop_cnt),
    .o_state        (o_state)
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // output monitor
  always @(negedge clk) begin
    if (o_out_wr != 8'h00) begin
      obs_q.push_back({o_out_wr, o_out_ctrl, o_out_data});
      obs_t.push_back(cyc);
    end
  end

  function automatic logic [7:0] em(input logic [7:0] dst);
`ifdef OQ_DEMUX_MIRROR_EN
    return dst | 8'h02;
`else
    return dst;
`endif
  endfunction

  function automatic logic [63:0] hdr(input logic [15:0] dst);
    return {dst, 48'h0001_0004_0020};
  endfunction

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic push(input logic [63:0] d, input logic [7:0] c);
    int n = 0;
    while (!o_in_rdy && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check("push_timeout", W'(0), W'(1));
    i_in_data = d;
    i_in_ctrl = c;
    i_in_wr   = 1'b1;
    @(negedge clk);
    i_in_wr   = 1'b0;
  endtask

  task automatic wr(input logic [63:0] d, input logic [7:0] c, input logic [7:0] m);
    push(d, c);
    if (m != 8'h00) exp_q.push_back({m, c, d});
  endtask

  task automatic check_stream(input string tag);
    repeat (15) @(negedge clk);
    check({tag, "_len"}, W'(obs_q.size()), W'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
      check({tag, "_word"}, obs_q[i], exp_q[i]);
    exp_q.delete();
    obs_q.delete();
    obs_t.delete();
  endtask

  task automatic check_counts(input string tag);
    check({tag, "_fwd_cnt"}, W'(o_pkt_fwd_cnt), W'(exp_fwd));
    check({tag, "_drop_cnt"}, W'(o_pkt_drop_cnt), W'(exp_drop));
  endtask

  initial begin
    int n;
    logic [7:0] m;
    i_reset   = 1'b0;
    i_in_data = '0;
    i_in_ctrl = '0;
    i_in_wr   = 1'b0;
    i_out_rdy = 8'hFF;
    repeat (3) @(negedge clk);

    // reset state
    check("rst_out_wr", W'(o_out_wr), W'(0));
    check("rst_out_data", W'({o_out_ctrl, o_out_data}), W'(0));
    check("rst_state", W'(o_state), W'(0));
    check("rst_in_rdy", W'(o_in_rdy), W'(1));
    check_counts("rst");
    i_reset = 1'b1;
    @(negedge clk);

    // unicast; only the selected queue is ready, the others must not stall
    m = em(8'h04);
    i_out_rdy = m;
    wr(hdr(16'h0004), 8'hFF, m);
    wr(64'hA1, 8'h00, m);
    wr(64'hA2, 8'h00, m);
    wr(64'hA3, 8'h00, m);
    wr(64'hA4, 8'h10, m);
    repeat (15) @(negedge clk);
    if (obs_t.size() == 5) check("uni_back_to_back", W'(obs_t[4] - obs_t[0]), W'(4));
    else check("uni_strobe_count", W'(obs_t.size()), W'(5));
    check_stream("uni");
    exp_fwd++;
    check_counts("uni");
    i_out_rdy = 8'hFF;

    // flood with stall on queue 4
    m = em(8'h55);
    i_out_rdy = 8'hEF;
    wr(hdr(16'h0055), 8'hFF, m);
    wr(64'hB1, 8'h00, m);
    wr(64'hB2, 8'h00, m);
    check("flood_in_rdy_nf", W'(o_in_rdy), W'(0));
    repeat (10) begin
      @(negedge clk);
      check("flood_stall_wr", W'(o_out_wr), W'(0));
    end
    check("flood_stall_state", W'(o_state), W'(1));
    i_out_rdy = 8'hFF;
    wr(64'hB3, 8'h00, m);
    wr(64'hB4, 8'h20, m);
    check_stream("flood");
    exp_fwd++;
    check_counts("flood");

    // empty mask, then a valid packet
    m = em(8'h00);
    wr(hdr(16'h0000), 8'hFF, m);
    wr(64'hC1, 8'h00, m);
    wr(64'hC2, 8'h00, m);
    wr(64'hC3, 8'h10, m);
    if (m == 8'h00) exp_drop++;
    else exp_fwd++;
    m = em(8'h08);
    wr(hdr(16'h0008), 8'hFF, m);
    wr(64'hD1, 8'h00, m);
    wr(64'hD2, 8'h30, m);
    check_stream("empty_mask");
    exp_fwd++;
    check_counts("empty_mask");

    // bad header: first word is not the IOQ header
    wr(64'hE0, 8'h01, 8'h00);
    wr(64'hE1, 8'h00, 8'h00);
    wr(64'hE2, 8'h10, 8'h00);
    check_stream("bad_hdr");
    exp_drop++;
    check_counts("bad_hdr");

    // back-to-back, then reset in the middle of the second packet
    fork
      begin
        wr(hdr(16'h0001), 8'hFF, em(8'h01));
        wr(64'hF1, 8'h00, em(8'h01));
        wr(64'hF2, 8'h00, em(8'h01));
        wr(64'hF3, 8'h10, em(8'h01));
        wr(hdr(16'h0002), 8'hFF, em(8'h02));
        for (int i = 0; i < 6; i++) wr(64'h100 + 64'(i), 8'h00, em(8'h02));
      end
    join_none
    n = 0;
    while (o_out_wr !== em(8'h02) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("b2b_reached_pkt2", W'(n < 100), W'(1));
    #2 i_reset = 1'b0;
    #1;
    check("midrst_out_wr", W'(o_out_wr), W'(0));
    check("midrst_state", W'(o_state), W'(0));
    exp_fwd = 0;
    exp_drop = 0;
    check_counts("midrst");
    wait fork;
    check("b2b_min_words", W'(obs_q.size() >= 5), W'(1));
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++)
      check("b2b_word", obs_q[i], exp_q[i]);
    exp_q.delete();
    obs_q.delete();
    obs_t.delete();
    @(negedge clk);
    i_reset = 1'b1;
    repeat (2) @(negedge clk);

    // recovery after reset
    m = em(8'h10);
    wr(hdr(16'h0010), 8'hFF, m);
    wr(64'h201, 8'h00, m);
    wr(64'h202, 8'h40, m);
    check_stream("post_rst");
    exp_fwd++;
    check_counts("post_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/output_queue_demux.md
Name: output_queue_demux

Overview:
- Consumes the packet stream after the output-port lookup stage and decodes the destination-port bitmap from the IOQ module header.
- Delivers each packet word to every selected output queue (unicast, flood or multicast) over a shared data bus with per-queue write strobes.
- Sits between the port-lookup stage and the per-port output queues; drops packets with an empty bitmap or a malformed header, and counts them.

Parameters:
- DATA_WIDTH, 64, datapath width.
- CTRL_WIDTH, DATA_WIDTH/8, control width.
- NUM_OUTPUT_QUEUES, 8, number of output queues; the low NUM_OUTPUT_QUEUES bits of the dst field are used.
- IO_QUEUE_STAGE_NUM, 8'hFF, ctrl value that marks the IOQ module header word.
- CNT_WIDTH, 16, width of the statistics counters.
- MIRROR_QUEUE, 1, queue index used by the optional mirror feature.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- in_data  in  DATA_WIDTH  word from lookup stage.
- in_ctrl  in  CTRL_WIDTH  ctrl from lookup stage.
- in_wr  in  1  input word valid.
- in_rdy  out  1  = !fifo_nearly_full.
- out_data  out  DATA_WIDTH  shared bus to queues.
- out_ctrl  out  CTRL_WIDTH  shared ctrl bus.
- out_wr  out  NUM_OUTPUT_QUEUES  per-queue write strobe; multiple bits may be set.
- out_rdy  in  NUM_OUTPUT_QUEUES  per-queue ready (nearly-full semantics).
- pkt_fwd_cnt  out  CNT_WIDTH  packets forwarded.
- pkt_drop_cnt  out  CNT_WIDTH  packets dropped (empty mask or bad header).

Behaviour:
- Reset (async assert, sync deassert): state=WAIT_HDR, dst_mask=0, out_wr=0, out_data=0, out_ctrl=0, counters=0, FIFO emptied.
- Input FIFO: 4 deep, first-word-fall-through. A write with in_wr while full is a protocol violation; the word is dropped and no counter changes.
- States:
  - WAIT_HDR: when FIFO is non-empty, inspect the head word.
    - head ctrl==IO_QUEUE_STAGE_NUM: latch dst_mask = head[`IOQ_DST_PORT_POS +: NUM_OUTPUT_QUEUES].
      - Mask nonzero -> FWD_HDR.
      - Mask zero -> DROP, pkt_drop_cnt+1.
    - head ctrl any other value (first word is not the IOQ header) -> DROP, pkt_drop_cnt+1.
    - The head word is not popped in WAIT_HDR.
  - FWD_HDR: forward words while ctrl!=0; the first word with ctrl==0 -> FWD_DATA (that word is forwarded in the same cycle).
  - FWD_DATA: forward words; the first word with ctrl!=0 is the EOP word. Forward it, pkt_fwd_cnt+1, -> WAIT_HDR.
  - DROP: pop words with no output; apply the same header/data/EOP tracking as forwarding; on EOP -> WAIT_HDR.
- Forward condition (fwd_go): FIFO non-empty AND &(out_rdy | ~dst_mask).
  - Queues outside the mask never stall.
  - Any selected queue not ready stalls all selected queues; no partial delivery.
- Latency: on a fwd_go cycle the head word is popped; on the next edge out_data/out_ctrl are registered and out_wr <= dst_mask. Otherwise out_wr <= 0.
- out_data/out_ctrl hold their last value when out_wr=0.
- The forwarded IOQ header word is unmodified.
- DROP pops one word per cycle whenever the FIFO is non-empty, independent of out_rdy.
- Counters saturate at all-ones; no wrap.
- A packet whose EOP arrives in the same cycle as the next header is written to the FIFO is handled naturally; there are no bubbles between back-to-back packets except the WAIT_HDR decode cycle.
- Reset mid-packet: in-flight words are discarded, and the outputs return to reset values asynchronously.

Optional Feature:
- Macro: OQ_DEMUX_MIRROR_EN.
- Defined:
  - Every forwarded packet also sets bit MIRROR_QUEUE in the latched dst_mask; out_rdy[MIRROR_QUEUE] then participates in the stall condition.
  - Packets with a zero decoded mask are mirrored rather than dropped, and pkt_drop_cnt counts only bad-header packets.
- Undefined: dst_mask is exactly the decoded field; MIRROR_QUEUE is unused.

Decomposition:
- Shared package/defines:
  - IOQ_DST_PORT_POS, IOQ_SRC_PORT_POS and IO_QUEUE_STAGE_NUM.
  - State encodings WAIT_HDR=2'd0, FWD_HDR=2'd1, FWD_DATA=2'd2, DROP=2'd3.
- Sub-module: fallthrough_small_fifo (WIDTH=CTRL_WIDTH+DATA_WIDTH, MAX_DEPTH_BITS=2) for input buffering. The state machine, strobe register and counters stay in the top module.

Test Plan:
- Unicast: IOQ header with dst=16'h0004, 1 header word, 3 data words, EOP ctrl=8'h10; all out_rdy=1 -> 5 words, each with out_wr=8'h04 one cycle after its pop; pkt_fwd_cnt=1.
- Flood with stall: dst=16'h0055; hold out_rdy[4]=0 for 10 cycles -> out_wr stays 0 throughout the stall; afterwards each word is strobed with 8'h55; in_rdy deasserts once the FIFO is nearly full.
- Empty mask: dst=0, 4-word packet -> no out_wr; pkt_drop_cnt=1; the next valid packet is forwarded normally.
- Bad header: first word ctrl=8'h01 -> packet dropped through EOP; pkt_drop_cnt=1; no strobes.
- Back-to-back: two packets (dst 8'h01, then 8'h02) with in_wr continuous -> strobes switch from 8'h01 to 8'h02 exactly at the packet boundary; reset asserted mid-second-packet -> out_wr=0 immediately and counters=0.
- With OQ_DEMUX_MIRROR_EN: dst=8'h04 -> strobes 8'h06; dst=0 -> strobes 8'h02; pkt_drop_cnt unchanged.
